// File: rtl/mem_fifo_mover.sv
// mem_fifo_mover: words are loaded into a source memory and moved through a small
// FIFO into a destination memory, which is then streamed out for readback.
module mem_fifo_mover #(
   parameter  int DW = 8,
   parameter  int N  = 16,
   parameter  int FD = 4,
   localparam int AW = $clog2(N + 1),
   localparam int FW = $clog2(FD + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   output logic          load_ready,
   input  logic          start,
   input  logic          hold,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_index,
   input  logic          out_ready,
   output logic          busy,
   output logic          done,
   output logic [FW-1:0] fifo_level,
   output logic [1:0]    fsm_state
);

   // Handshakes: a word moves on a rising edge where valid && ready are both high;
   // ready never depends on valid, and a stalled out_valid keeps data/index stable.

   localparam int IW = $clog2(N);
   localparam int PW = $clog2(FD);
   localparam logic [AW-1:0] N_L  = AW'(N);
   localparam logic [FW-1:0] FD_L = FW'(FD);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_DONE} state_t;

   state_t        state;
   logic [DW-1:0] src_mem [N];
   logic [DW-1:0] dst_mem [N];
   logic [DW-1:0] fifo_mem [FD];
   logic [AW-1:0] load_cnt, push_idx, pop_idx, rd_idx;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          load_fire, full, empty, push, pop;

   assign load_fire = load_valid && load_ready;
   assign full      = (fifo_level == FD_L);
   assign empty     = (fifo_level == '0);
   assign pop       = (state == S_XFER) && !empty && !hold;
   // A pop frees the head slot in the same edge, so a push at full is still safe.
   assign push      = (state == S_XFER) && (push_idx < load_cnt) && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         load_cnt   <= '0;
         push_idx   <= '0;
         pop_idx    <= '0;
         rd_idx     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (load_fire) load_cnt <= load_cnt + 1'b1;
               if (start && (load_cnt != '0)) state <= S_XFER;
            end
            S_XFER: begin
               if (push) begin
                  wr_ptr   <= wr_ptr + 1'b1;
                  push_idx <= push_idx + 1'b1;
               end
               if (pop) begin
                  rd_ptr  <= rd_ptr + 1'b1;
                  pop_idx <= pop_idx + 1'b1;
                  if (pop_idx + 1'b1 == load_cnt) state <= S_DRAIN;
               end
               if (push && !pop)      fifo_level <= fifo_level + 1'b1;
               else if (pop && !push) fifo_level <= fifo_level - 1'b1;
            end
            S_DRAIN: begin
               if (out_ready) begin
                  rd_idx <= rd_idx + 1'b1;
                  if (rd_idx == load_cnt - 1'b1) state <= S_DONE;
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               load_cnt <= '0;
               push_idx <= '0;
               pop_idx  <= '0;
               rd_idx   <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Storage is never cleared; only the counters above are.
   always_ff @(posedge clk) begin
      if (!rst && load_fire) src_mem[load_cnt[IW-1:0]] <= load_data;
      if (!rst && push)      fifo_mem[wr_ptr] <= src_mem[push_idx[IW-1:0]];
      if (!rst && pop)       dst_mem[pop_idx[IW-1:0]] <= fifo_mem[rd_ptr];
   end

   assign load_ready = (state == S_IDLE) && (load_cnt < N_L);
   assign out_valid  = (state == S_DRAIN);
   assign out_data   = (state == S_DRAIN) ? dst_mem[rd_idx[IW-1:0]] : '0;
   assign out_index  = (state == S_DRAIN) ? rd_idx : '0;
   assign busy       = (state == S_XFER) || (state == S_DRAIN);
   assign done       = (state == S_DONE);
   assign fsm_state  = state;

endmodule

// File: doc/mem_fifo_mover.md
MEM_FIFO_MOVER -- requirements
Module: mem_fifo_mover

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter N, default 16, source/destination memory entries (N >= 2).
REQ-003 SHALL have parameter FD, default 4, internal FIFO depth, power of two >= 2.
REQ-004 SHALL have derived localparams AW = clog2(N+1) and FW = clog2(FD+1).
REQ-005 clk  in  1  clock; all logic SHALL be clocked on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 load_valid  in  1  load word offered.
REQ-008 load_data  in  DW  load word.
REQ-009 load_ready  out  1  block accepts a load word this cycle.
REQ-010 start  in  1  begin transfer of loaded words.
REQ-011 hold  in  1  stalls the FIFO consumer side (pop) while high.
REQ-012 out_valid  out  1  readback word valid.
REQ-013 out_data  out  DW  readback word.
REQ-014 out_index  out  AW  index of out_data in the destination memory.
REQ-015 out_ready  in  1  downstream accepts readback word.
REQ-016 busy  out  1  high in XFER or DRAIN.
REQ-017 done  out  1  one-cycle pulse after last readback word is accepted.
REQ-018 fifo_level  out  FW  current FIFO occupancy, 0..FD.

Function
REQ-019 SHALL implement FSM states IDLE, XFER, DRAIN, DONE; each state SHALL persist in the next cycle unless a transition below applies.
REQ-020 In IDLE, load_ready SHALL equal (load_cnt < N), and each cycle with load_valid && load_ready SHALL write src_mem[load_cnt] and increment load_cnt.
REQ-021 load_ready SHALL be 0 in XFER, DRAIN, DONE; load_valid SHALL be ignored there.
REQ-022 IDLE -> XFER SHALL occur on start && load_cnt != 0; start with load_cnt == 0 SHALL be ignored; start in other states SHALL be ignored.
REQ-023 A load handshake and start in the same IDLE cycle SHALL both take effect; the transfer SHALL include the word just loaded.
REQ-024 In XFER, push SHALL occur when push_idx < load_cnt and FIFO not full, writing src_mem[push_idx] and incrementing push_idx.
REQ-025 In XFER, pop SHALL occur when FIFO not empty and hold == 0, writing FIFO head to dst_mem[pop_idx] and incrementing pop_idx.
REQ-026 Push and pop in the same cycle SHALL both occur, including at full and at empty-with-push (no pop of the word being pushed that cycle); fifo_level SHALL be unchanged.
REQ-027 FIFO pointers SHALL wrap modulo FD; full = (fifo_level == FD), empty = (fifo_level == 0).
REQ-028 XFER -> DRAIN SHALL occur in the cycle after the pop with pop_idx reaching load_cnt.
REQ-029 Word order SHALL be preserved: dst_mem[i] == src_mem[i] for all i < load_cnt.
REQ-030 Minimum XFER latency: first word SHALL reach dst_mem 2 cycles after entering XFER (push cycle, then pop cycle).
REQ-031 In DRAIN, out_valid SHALL be 1, out_data = dst_mem[rd_idx], out_index = rd_idx, starting at rd_idx 0.
REQ-032 out_data/out_index SHALL stay stable while out_valid && !out_ready.
REQ-033 On out_valid && out_ready, rd_idx SHALL increment; on the last index (load_cnt-1) the FSM SHALL go to DONE.
REQ-034 DONE SHALL last exactly one cycle with done = 1, then go to IDLE with load_cnt, push_idx, pop_idx, rd_idx cleared to 0.
REQ-035 busy SHALL be 1 exactly in XFER and DRAIN.
REQ-036 Memory contents SHALL NOT be cleared by reset or DONE; only counters clear.

Reset
REQ-037 rst SHALL force state IDLE, all counters and FIFO pointers 0, and outputs load_ready = 1, out_valid = 0, out_data = 0, out_index = 0, busy = 0, done = 0, fifo_level = 0 in the following cycle.
REQ-038 rst asserted mid-XFER or mid-DRAIN SHALL abort the operation with no done pulse; rst SHALL have priority over every other input.

Verification
REQ-039 Defaults; load 16 words 0x10..0x1F, start, out_ready = 1, hold = 0 -> out_data 0x10..0x1F on out_index 0..15, done pulse once, busy low after.
REQ-040 Load 6 words, start with hold = 1 for 10 cycles -> fifo_level saturates at 4, pushes stall; release hold -> all 6 words read back in order.
REQ-041 Load 3 words with start in the same cycle as the 3rd load -> 3 words transferred; start with load_cnt = 0 -> state stays IDLE.
REQ-042 In DRAIN, drop out_ready for 5 cycles at out_index 2 -> out_data/out_index held constant, no skipped or duplicated index.
REQ-043 Assert rst during XFER with fifo_level = 3 -> next cycle fifo_level = 0, busy = 0, load_ready = 1, no done pulse; a new load/transfer then completes correctly.
REQ-044 Parameters DW = 16, N = 5, FD = 2 -> 5 words 0xA5A0..0xA5A4 read back in order with correct full/empty behaviour and pointer wrap.
